// File: rtl/adc_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adc_seq_ctrl_if                                                 |
// | Purpose  : Pin/consumer bundle of the multi-channel SAR ADC sequencer.     |
// |            slave  = sequencer side, master = ADC pins + sample consumer.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface adc_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              start;
    logic              continuous;
    logic [NUM_CH-1:0] ch_mask;
    logic              EOC;
    logic [DATA_W-1:0] Data;
    logic [CH_W-1:0]   MUX_SEL;
    logic              CONVST;
    logic              CS;
    logic              RD;
    logic [DATA_W-1:0] Valid_Data;
    logic [CH_W-1:0]   Valid_Ch;
    logic              data_valid;
    logic              ADC_ready;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  start, continuous, ch_mask, EOC, Data,
        output MUX_SEL, CONVST, CS, RD, Valid_Data, Valid_Ch,
               data_valid, ADC_ready, busy, timeout_err
    );

    modport master (
        output start, continuous, ch_mask, EOC, Data,
        input  MUX_SEL, CONVST, CS, RD, Valid_Data, Valid_Ch,
               data_valid, ADC_ready, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adc_seq_ctrl                                                    |
// | Purpose  : Sweeps the enabled mux channels of a parallel SAR ADC: settle,  |
// |            CONVST pulse, wait for EOC, CS/RD read, tagged sample capture.  |
// | Options  : define ADC_EOC_TIMEOUT_EN to bound the EOC wait and flag a     |
// |            sticky timeout_err instead of waiting forever.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adc_seq_ctrl #(
    parameter int DATA_W         = 8,
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CONVST_CYCLES  = 4,
    parameter int RD_CYCLES      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire           clk_100M,
    input  wire           reset,
    adc_seq_ctrl_if.slave bus
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int c_CHX_W = CH_W + 1;

`ifdef ADC_EOC_TIMEOUT_EN
    localparam int c_TO_TOP = TIMEOUT_CYCLES;
`else
    // The EOC wait has no limit here, so the timeout length does not size the counter.
    localparam int c_TO_TOP = 0 * TIMEOUT_CYCLES;
`endif
    localparam int c_M1      = (SETTLE_CYCLES > CONVST_CYCLES) ? SETTLE_CYCLES : CONVST_CYCLES;
    localparam int c_M2      = (c_M1 > RD_CYCLES) ? c_M1 : RD_CYCLES;
    localparam int c_CNT_TOP = (c_M2 > c_TO_TOP) ? c_M2 : c_TO_TOP;
    localparam int c_CNT_W   = $clog2(c_CNT_TOP + 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SETTLE   = 3'd1;
    localparam logic [2:0] c_ST_CONV     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_EOC = 3'd3;
    localparam logic [2:0] c_ST_READ     = 3'd4;
    localparam logic [2:0] c_ST_NEXT     = 3'd5;

    // Lowest set bit of mask at or above index from; MSB of result = found.
    function automatic logic [c_CHX_W-1:0] f_find_ch(input logic [NUM_CH-1:0]  mask,
                                                     input logic [c_CHX_W-1:0] from);
        logic [c_CHX_W-1:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (c_CHX_W'(i) >= from)) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_eoc_meta;
    logic               r_eoc_s;

    logic [NUM_CH-1:0]  r_mask,       w_mask_nxt;
    logic [CH_W-1:0]    r_mux_sel,    w_mux_sel_nxt;
    logic               r_convst,     w_convst_nxt;
    logic               r_cs,         w_cs_nxt;
    logic               r_rd,         w_rd_nxt;
    logic [DATA_W-1:0]  r_valid_data, w_valid_data_nxt;
    logic [CH_W-1:0]    r_valid_ch,   w_valid_ch_nxt;
    logic               r_data_valid, w_data_valid_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_adc_ready,  w_adc_ready_nxt;
`ifdef ADC_EOC_TIMEOUT_EN
    logic               r_timeout_err, w_timeout_err_nxt;
    logic               w_timeout;
`endif

    logic [c_CHX_W-1:0] w_higher;
    logic [c_CHX_W-1:0] w_lowest;
    logic               w_settle_done;
    logic               w_conv_done;
    logic               w_read_done;

    assign w_higher      = f_find_ch(r_mask, c_CHX_W'({1'b0, r_mux_sel}) + c_CHX_W'(1));
    assign w_lowest      = f_find_ch(bus.ch_mask, '0);
    // r_cnt saturates, so a stretched SETTLE keeps satisfying this compare.
    assign w_settle_done = (r_cnt >= c_CNT_W'(SETTLE_CYCLES - 1));
    assign w_conv_done   = (r_cnt == c_CNT_W'(CONVST_CYCLES - 1));
    assign w_read_done   = (r_cnt == c_CNT_W'(RD_CYCLES - 1));
`ifdef ADC_EOC_TIMEOUT_EN
    assign w_timeout     = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) && r_eoc_s;
`endif

    // Two-flop synchroniser for the asynchronous active-low EOC.
    always_ff @(posedge clk_100M) begin
        if (reset) begin
            r_eoc_meta <= 1'b1;
            r_eoc_s    <= 1'b1;
        end else begin
            r_eoc_meta <= bus.EOC;
            r_eoc_s    <= r_eoc_meta;
        end
    end

    // State register, per-state cycle counter and registered outputs.
    always_ff @(posedge clk_100M) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_mask        <= '0;
            r_mux_sel     <= '0;
            r_convst      <= 1'b1;
            r_cs          <= 1'b1;
            r_rd          <= 1'b1;
            r_valid_data  <= '0;
            r_valid_ch    <= '0;
            r_data_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_adc_ready   <= 1'b1;
`ifdef ADC_EOC_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_W'(c_CNT_TOP)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            r_mask        <= w_mask_nxt;
            r_mux_sel     <= w_mux_sel_nxt;
            r_convst      <= w_convst_nxt;
            r_cs          <= w_cs_nxt;
            r_rd          <= w_rd_nxt;
            r_valid_data  <= w_valid_data_nxt;
            r_valid_ch    <= w_valid_ch_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_adc_ready   <= w_adc_ready_nxt;
`ifdef ADC_EOC_TIMEOUT_EN
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start && (bus.ch_mask != '0)) begin
                    w_state_nxt = c_ST_SETTLE;
                end
            end
            c_ST_SETTLE: begin
                // EOC still asserted from the previous read holds off the next conversion.
                if (w_settle_done && r_eoc_s) begin
                    w_state_nxt = c_ST_CONV;
                end
            end
            c_ST_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = c_ST_WAIT_EOC;
                end
            end
            c_ST_WAIT_EOC: begin
                if (!r_eoc_s) begin
                    w_state_nxt = c_ST_READ;
                end
`ifdef ADC_EOC_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = c_ST_NEXT;
                end
`endif
            end
            c_ST_READ: begin
                if (w_read_done) begin
                    w_state_nxt = c_ST_NEXT;
                end
            end
            c_ST_NEXT: begin
                if (w_higher[CH_W]) begin
                    w_state_nxt = c_ST_SETTLE;
                end else if (bus.continuous && w_lowest[CH_W]) begin
                    w_state_nxt = c_ST_SETTLE;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition taken.
    always_comb begin
        w_mask_nxt        = r_mask;
        w_mux_sel_nxt     = r_mux_sel;
        w_valid_data_nxt  = r_valid_data;
        w_valid_ch_nxt    = r_valid_ch;
        w_data_valid_nxt  = 1'b0;
        w_convst_nxt      = (w_state_nxt != c_ST_CONV);
        w_cs_nxt          = (w_state_nxt != c_ST_READ);
        w_rd_nxt          = (w_state_nxt != c_ST_READ);
        w_busy_nxt        = (w_state_nxt != c_ST_IDLE);
        w_adc_ready_nxt   = (w_state_nxt == c_ST_IDLE);
`ifdef ADC_EOC_TIMEOUT_EN
        w_timeout_err_nxt = r_timeout_err;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (w_state_nxt == c_ST_SETTLE) begin
                    w_mask_nxt        = bus.ch_mask;
                    w_mux_sel_nxt     = w_lowest[CH_W-1:0];
`ifdef ADC_EOC_TIMEOUT_EN
                    w_timeout_err_nxt = 1'b0;
`endif
                end
            end
`ifdef ADC_EOC_TIMEOUT_EN
            c_ST_WAIT_EOC: begin
                if (w_state_nxt == c_ST_NEXT) begin
                    w_timeout_err_nxt = 1'b1;
                end
            end
`endif
            c_ST_READ: begin
                if (w_state_nxt == c_ST_NEXT) begin
                    w_valid_data_nxt = bus.Data;
                    w_valid_ch_nxt   = r_mux_sel;
                    w_data_valid_nxt = 1'b1;
                end
            end
            c_ST_NEXT: begin
                if (w_higher[CH_W]) begin
                    w_mux_sel_nxt = w_higher[CH_W-1:0];
                end else if (bus.continuous) begin
                    w_mask_nxt = bus.ch_mask;
                    if (w_lowest[CH_W]) begin
                        w_mux_sel_nxt = w_lowest[CH_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.MUX_SEL    = r_mux_sel;
    assign bus.CONVST     = r_convst;
    assign bus.CS         = r_cs;
    assign bus.RD         = r_rd;
    assign bus.Valid_Data = r_valid_data;
    assign bus.Valid_Ch   = r_valid_ch;
    assign bus.data_valid = r_data_valid;
    assign bus.busy       = r_busy;
    assign bus.ADC_ready  = r_adc_ready;
`ifdef ADC_EOC_TIMEOUT_EN
    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_adc_seq_ctrl                                                 |
// | Purpose  : Scoreboard bench for adc_seq_ctrl with a behavioural ADC model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_adc_seq_ctrl;
    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int SETTLE = 2;
    localparam int CONVW  = 4;
    localparam int RDW    = 3;
    localparam int TOUT   = 16;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk_100M = 1'b0;
    logic reset    = 1'b1;
    always #5 clk_100M = ~clk_100M;

    adc_seq_ctrl_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    adc_seq_ctrl #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE),
        .CONVST_CYCLES(CONVW), .RD_CYCLES(RDW), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk_100M(clk_100M),
        .reset(reset),
        .bus(bus)
    );

    exp_t              sb_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                n_pop = 0;
    logic [DATA_W-1:0] ch_val [NUM_CH];
    int                eoc_dly_fixed = 8;   // 0 selects a random EOC latency
    int                eoc_hold = 0;        // extra cycles EOC stays low after the read
    bit                skip_ch0 = 1'b0;     // ADC never answers a ch0 conversion

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected samples of one sweep: enabled channels in ascending order.
    task automatic push_sweep(input logic [NUM_CH-1:0] m);
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                e.ch   = CH_W'(c);
                e.data = ch_val[c];
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] m);
        bus.ch_mask = m;
        bus.start   = 1'b1;
        @(negedge clk_100M);
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bus.ADC_ready !== 1'b1 && n < budget) begin
            @(negedge clk_100M);
            n++;
        end
        check(name, bus.ADC_ready, 1);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (n_pop < target && n < budget) begin
            @(negedge clk_100M);
            n++;
        end
        check(name, (n_pop >= target), 1);
    endtask

    task automatic randomize_vals();
        for (int c = 0; c < NUM_CH; c++) ch_val[c] = DATA_W'($urandom);
    endtask

    // Behavioural ADC: converts the selected channel, answers with EOC low and data.
    initial begin
        logic [CH_W-1:0] ch;
        int              d;
        bus.EOC  = 1'b1;
        bus.Data = '0;
        forever begin
            @(negedge bus.CONVST);
            ch = bus.MUX_SEL;
            @(posedge bus.CONVST);
            if (!(skip_ch0 && ch == '0)) begin
                d = (eoc_dly_fixed > 0) ? eoc_dly_fixed : int'($urandom_range(1, 10));
                repeat (d) @(negedge clk_100M);
                bus.EOC  = 1'b0;
                bus.Data = ch_val[ch];
                @(posedge bus.RD);
                repeat (eoc_hold) @(negedge clk_100M);
                @(negedge clk_100M);
                bus.EOC = 1'b1;
            end
        end
    end

    // Scoreboard monitor plus the CONVST / read-strobe separation rule.
    always @(negedge clk_100M) begin
        if (!reset) begin
            check("convst_read_overlap", (bus.CONVST === 1'b0) && (bus.CS === 1'b0 || bus.RD === 1'b0), 0);
        end
        if (bus.data_valid === 1'b1) begin
            exp_t e;
            n_pop++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_data_valid: got ch %0d data %0h, expected no sample", bus.Valid_Ch, bus.Valid_Data);
            end else begin
                e = sb_q.pop_front();
                check("valid_ch", bus.Valid_Ch, e.ch);
                check("valid_data", bus.Valid_Data, e.data);
                check("strobes_high_at_valid", {bus.CS, bus.RD}, 2'b11);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] m;
        int k, w, base, total;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask    = '0;
        for (int c = 0; c < NUM_CH; c++) ch_val[c] = DATA_W'(8'hA0 + c);

        // Reset state
        reset = 1'b1;
        repeat (5) @(negedge clk_100M);
        check("rst_convst", bus.CONVST, 1);
        check("rst_cs_rd", {bus.CS, bus.RD}, 2'b11);
        check("rst_ready", bus.ADC_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_mux_sel", bus.MUX_SEL, 0);
        check("rst_valid_data", bus.Valid_Data, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_100M);

        // Directed sweep of channels 1 and 3 with CONVST timing
        eoc_dly_fixed = 8;
        base = n_pop;
        push_sweep(4'b1010);
        pulse_start(4'b1010);
        check("start_busy", bus.busy, 1);
        check("start_ready", bus.ADC_ready, 0);
        check("start_mux_sel", bus.MUX_SEL, 1);
        k = 1;
        while (bus.CONVST !== 1'b0 && k < 50) begin
            @(negedge clk_100M);
            k++;
        end
        check("convst_fall_delay", k, SETTLE + 1);
        w = 0;
        while (bus.CONVST === 1'b0 && w < 50) begin
            @(negedge clk_100M);
            w++;
        end
        check("convst_low_width", w, CONVW);
        wait_idle(500, "sweep1010_idle");
        check("sweep1010_count", n_pop - base, 2);
        check("sweep1010_sb_empty", sb_q.size(), 0);

        // Start with an empty mask is ignored
        pulse_start('0);
        check("mask0_ready", bus.ADC_ready, 1);
        repeat (3) @(negedge clk_100M);
        check("mask0_busy", bus.busy, 0);

        // Random sweeps; mask changes and starts during a sweep have no effect
        eoc_dly_fixed = 0;
        for (int it = 0; it < 6; it++) begin
            randomize_vals();
            m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            push_sweep(m);
            pulse_start(m);
            bus.ch_mask = NUM_CH'($urandom);
            repeat (4) @(negedge clk_100M);
            bus.ch_mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            bus.start   = 1'b1;
            @(negedge clk_100M);
            bus.start   = 1'b0;
            wait_idle(3000, "rand_sweep_idle");
            check("rand_sweep_sb_empty", sb_q.size(), 0);
        end

        // Continuous mode: three sweeps, then clear during the last channel
        for (int it = 0; it < 2; it++) begin
            randomize_vals();
            m = (it == 0) ? NUM_CH'(1) : NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            total = 3 * $countones(m);
            for (int s = 0; s < 3; s++) push_sweep(m);
            base = n_pop;
            bus.continuous = 1'b1;
            pulse_start(m);
            repeat (6) @(negedge clk_100M);
            bus.ch_mask = ~m;
            bus.start   = 1'b1;
            @(negedge clk_100M);
            bus.start   = 1'b0;
            bus.ch_mask = m;
            wait_pops(base + total - 1, 5000, "cont_progress");
            k = 0;
            while (bus.CONVST !== 1'b0 && k < 200) begin
                @(negedge clk_100M);
                k++;
            end
            bus.continuous = 1'b0;
            wait_idle(1000, "cont_idle");
            check("cont_count", n_pop - base, total);
            check("cont_sb_empty", sb_q.size(), 0);
        end

        // EOC held low after a read stretches SETTLE
        randomize_vals();
        eoc_dly_fixed = 3;
        eoc_hold = 20;
        base = n_pop;
        push_sweep(4'b0011);
        pulse_start(4'b0011);
        wait_pops(base + 1, 500, "hold_first_sample");
        k = 0;
        while (bus.CONVST !== 1'b0 && k < 200) begin
            @(negedge clk_100M);
            k++;
        end
        eoc_hold = 0;
        check("hold_settle_extended", (k >= 20), 1);
        wait_idle(500, "hold_idle");
        check("hold_sb_empty", sb_q.size(), 0);
        eoc_dly_fixed = 0;

`ifdef ADC_EOC_TIMEOUT_EN
        // ch0 never answers: flag, skip its sample, still convert ch1
        randomize_vals();
        skip_ch0 = 1'b1;
        push_sweep(4'b0010);
        pulse_start(4'b0011);
        wait_idle(1000, "timeout_idle");
        check("timeout_err_set", bus.timeout_err, 1);
        check("timeout_sb_empty", sb_q.size(), 0);
        skip_ch0 = 1'b0;
        push_sweep(4'b0001);
        pulse_start(4'b0001);
        check("timeout_err_cleared", bus.timeout_err, 0);
        wait_idle(500, "timeout_recover_idle");
        check("timeout_recover_sb_empty", sb_q.size(), 0);
`else
        check("timeout_err_const", bus.timeout_err, 0);
`endif

        // Reset while reading: strobes release at once, no sample delivered
        randomize_vals();
        base = n_pop;
        pulse_start(4'b0100);
        k = 0;
        while (bus.RD !== 1'b0 && k < 200) begin
            @(negedge clk_100M);
            k++;
        end
        check("rst_read_reached", bus.RD, 0);
        reset = 1'b1;
        @(negedge clk_100M);
        check("rst_read_strobes", {bus.CS, bus.RD}, 2'b11);
        check("rst_read_ready", bus.ADC_ready, 1);
        check("rst_read_busy", bus.busy, 0);
        check("rst_read_no_valid", bus.data_valid, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk_100M);
        check("rst_read_no_sample", n_pop - base, 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
